// File: rtl/tpu_tile_scheduler.sv
// Tile sequencer for a tiled GEMM on the systolic array: walks (m,n,k) tiles,
// derives SRAM base addresses and accumulate flags, and handshakes each tile.
module tpu_tile_scheduler #(
    parameter int unsigned ARRAY_SIZE     = 8,
    parameter int unsigned TILE_WORDS     = 2 * ARRAY_SIZE,
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_m_m1,
    input  logic [3:0]        cmd_n_m1,
    input  logic [3:0]        cmd_k_m1,
    input  logic              abort,
    output logic              tpu_start,
    input  logic              tpu_done,
    output logic [3:0]        tile_m,
    output logic [3:0]        tile_n,
    output logic [3:0]        tile_k,
    output logic [ADDR_W-1:0] a_base_addr,
    output logic [ADDR_W-1:0] b_base_addr,
    output logic [ADDR_W-1:0] c_base_addr,
    output logic              acc_clear,
    output logic              acc_last,
    output logic              busy,
    output logic [12:0]       tiles_done_cnt,
    output logic              sched_done,
    output logic              sched_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_WAIT_DONE,
        S_ADVANCE,
        S_FINISH,
        S_ERR
    } state_t;

    state_t            state;
    logic [3:0]        m_m1;
    logic [3:0]        n_m1;
    logic [3:0]        k_m1;
    logic [15:0]       watchdog;
    logic [ADDR_W-1:0] a_next;
    logic [ADDR_W-1:0] b_next;
    logic [ADDR_W-1:0] c_next;
    logic              last_tile;
    logic              wd_expire;

    // Products are formed at 32 bits and only then truncated to the address width.
    always_comb begin
        a_next = ADDR_W'((32'(tile_m) * (32'(k_m1) + 32'd1) + 32'(tile_k)) * TILE_WORDS);
        b_next = ADDR_W'((32'(tile_k) * (32'(n_m1) + 32'd1) + 32'(tile_n)) * TILE_WORDS);
        c_next = ADDR_W'((32'(tile_m) * (32'(n_m1) + 32'd1) + 32'(tile_n)) * TILE_WORDS);
        last_tile = (tile_m == m_m1) && (tile_n == n_m1) && (tile_k == k_m1);
        wd_expire = (32'(watchdog) + 32'd1) >= (TIMEOUT_CYCLES - 32'd1);
    end

    assign cmd_ready  = (state == S_IDLE) || (state == S_ERR);
    assign busy       = !cmd_ready;
    assign tpu_start  = (state == S_ISSUE);
    assign sched_done = (state == S_FINISH);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state          <= S_IDLE;
            m_m1           <= '0;
            n_m1           <= '0;
            k_m1           <= '0;
            tile_m         <= '0;
            tile_n         <= '0;
            tile_k         <= '0;
            a_base_addr    <= '0;
            b_base_addr    <= '0;
            c_base_addr    <= '0;
            acc_clear      <= 1'b0;
            acc_last       <= 1'b0;
            tiles_done_cnt <= '0;
            sched_err      <= 1'b0;
            watchdog       <= '0;
        end else if (abort && state != S_IDLE) begin
            // Abort outranks done and timeout; counters and tile indices are kept.
            state     <= S_IDLE;
            sched_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ERR: begin
                    if (cmd_valid) begin
                        m_m1           <= cmd_m_m1;
                        n_m1           <= cmd_n_m1;
                        k_m1           <= cmd_k_m1;
                        tile_m         <= '0;
                        tile_n         <= '0;
                        tile_k         <= '0;
                        tiles_done_cnt <= '0;
                        sched_err      <= 1'b0;
                        state          <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    a_base_addr <= a_next;
                    b_base_addr <= b_next;
                    c_base_addr <= c_next;
                    acc_clear   <= (tile_k == 4'd0);
                    acc_last    <= (tile_k == k_m1);
                    state       <= S_ISSUE;
                end
                S_ISSUE: begin
                    watchdog <= '0;
                    state    <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (tpu_done) begin
                        tiles_done_cnt <= tiles_done_cnt + 13'd1;
                        state          <= last_tile ? S_FINISH : S_ADVANCE;
                    end else if (wd_expire) begin
                        sched_err <= 1'b1;
                        state     <= S_ERR;
                    end else begin
                        watchdog <= watchdog + 16'd1;
                    end
                end
                S_ADVANCE: begin
                    // k innermost, then n, then m.
                    if (tile_k == k_m1) begin
                        tile_k <= '0;
                        if (tile_n == n_m1) begin
                            tile_n <= '0;
                            tile_m <= tile_m + 4'd1;
                        end else begin
                            tile_n <= tile_n + 4'd1;
                        end
                    end else begin
                        tile_k <= tile_k + 4'd1;
                    end
                    state <= S_SETUP;
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Directed bench for tpu_tile_scheduler: tile-order table for a 2x2x2 job,
// formula-checked jobs, plus timeout, abort, reset and address-wrap sequences.
module tb_tpu_tile_scheduler;

    localparam int unsigned AS      = 8;
    localparam int unsigned TW      = 2 * AS;
    localparam int unsigned AW      = 8;
    localparam int unsigned TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_m_m1 = '0;
    logic [3:0]    cmd_n_m1 = '0;
    logic [3:0]    cmd_k_m1 = '0;
    logic          abort = 1'b0;
    logic          tpu_start;
    logic          tpu_done = 1'b0;
    logic [3:0]    tile_m;
    logic [3:0]    tile_n;
    logic [3:0]    tile_k;
    logic [AW-1:0] a_base_addr;
    logic [AW-1:0] b_base_addr;
    logic [AW-1:0] c_base_addr;
    logic          acc_clear;
    logic          acc_last;
    logic          busy;
    logic [12:0]   tiles_done_cnt;
    logic          sched_done;
    logic          sched_err;

    int n_cmp = 0;
    int n_bad = 0;

    tpu_tile_scheduler #(
        .ARRAY_SIZE    (AS),
        .TILE_WORDS    (TW),
        .ADDR_W        (AW),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk           (clk),
        .arst          (arst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_m_m1      (cmd_m_m1),
        .cmd_n_m1      (cmd_n_m1),
        .cmd_k_m1      (cmd_k_m1),
        .abort         (abort),
        .tpu_start     (tpu_start),
        .tpu_done      (tpu_done),
        .tile_m        (tile_m),
        .tile_n        (tile_n),
        .tile_k        (tile_k),
        .a_base_addr   (a_base_addr),
        .b_base_addr   (b_base_addr),
        .c_base_addr   (c_base_addr),
        .acc_clear     (acc_clear),
        .acc_last      (acc_last),
        .busy          (busy),
        .tiles_done_cnt(tiles_done_cnt),
        .sched_done    (sched_done),
        .sched_err     (sched_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned tm, tn, tk, a, b, c;
        bit          clr, last;
    } tile_vec_t;

    typedef struct {
        int unsigned m, n, k, delay;
        bit          use_tbl;
    } job_t;

    tile_vec_t tbl[8];
    job_t      jobs[5];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int unsigned m, input int unsigned n, input int unsigned k);
        cmd_m_m1  = 4'(m);
        cmd_n_m1  = 4'(n);
        cmd_k_m1  = 4'(k);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(output int gap);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!tpu_start && gap < 40);
    endtask

    task automatic pulse_done();
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0;
    endtask

    task automatic run_job(input int unsigned m, input int unsigned n, input int unsigned k,
                           input int unsigned delay, input bit use_tbl);
        int gap;
        int extra;
        int idx;
        bit first;
        bit last;
        extra = 0;
        idx   = 0;
        first = 1'b1;
        send_cmd(m, n, k);
        check("cnt_cleared", tiles_done_cnt, 0);
        check("err_cleared", sched_err, 0);
        for (int unsigned mi = 0; mi <= m; mi++)
            for (int unsigned ni = 0; ni <= n; ni++)
                for (int unsigned ki = 0; ki <= k; ki++) begin
                    last = (mi == m) && (ni == n) && (ki == k);
                    wait_start(gap);
                    check("start_gap", gap, first ? 1 : 2);
                    first = 1'b0;
                    check("tile_m", tile_m, mi);
                    check("tile_n", tile_n, ni);
                    check("tile_k", tile_k, ki);
                    check("a_base", a_base_addr, ((mi * (k + 1) + ki) * TW) % 256);
                    check("b_base", b_base_addr, ((ki * (n + 1) + ni) * TW) % 256);
                    check("c_base", c_base_addr, ((mi * (n + 1) + ni) * TW) % 256);
                    check("acc_clear", acc_clear, (ki == 0) ? 1 : 0);
                    check("acc_last", acc_last, (ki == k) ? 1 : 0);
                    if (m == 15 && mi == 1 && ni == 0)
                        check("c_wrap", c_base_addr, 0);
                    if (use_tbl) begin
                        check("tbl_m", tile_m, tbl[idx].tm);
                        check("tbl_n", tile_n, tbl[idx].tn);
                        check("tbl_k", tile_k, tbl[idx].tk);
                        check("tbl_a", a_base_addr, tbl[idx].a);
                        check("tbl_b", b_base_addr, tbl[idx].b);
                        check("tbl_c", c_base_addr, tbl[idx].c);
                        check("tbl_clr", acc_clear, tbl[idx].clr);
                        check("tbl_last", acc_last, tbl[idx].last);
                        idx++;
                    end
                    repeat (delay) begin
                        tick();
                        if (tpu_start) extra++;
                    end
                    pulse_done();
                    check("sched_done_pulse", sched_done, last ? 1 : 0);
                end
        check("extra_starts", extra, 0);
        check("final_cnt", tiles_done_cnt, (m + 1) * (n + 1) * (k + 1));
        tick();
        check("sched_done_drop", sched_done, 0);
        check("idle_ready", cmd_ready, 1);
    endtask

    task automatic run_timeout();
        int gap;
        int n_wait;
        send_cmd(0, 0, 0);
        wait_start(gap);
        check("to_start_gap", gap, 1);
        n_wait = 0;
        do begin
            tick();
            n_wait++;
        end while (!cmd_ready && n_wait < 60);
        check("to_cycles", n_wait, 16);
        check("to_err", sched_err, 1);
        check("to_busy", busy, 0);
        check("to_cnt", tiles_done_cnt, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int gap;

        tbl[0] = '{0, 0, 0,  0,  0,  0, 1, 0};
        tbl[1] = '{0, 0, 1, 16, 32,  0, 0, 1};
        tbl[2] = '{0, 1, 0,  0, 16, 16, 1, 0};
        tbl[3] = '{0, 1, 1, 16, 48, 16, 0, 1};
        tbl[4] = '{1, 0, 0, 32,  0, 32, 1, 0};
        tbl[5] = '{1, 0, 1, 48, 32, 32, 0, 1};
        tbl[6] = '{1, 1, 0, 32, 16, 48, 1, 0};
        tbl[7] = '{1, 1, 1, 48, 48, 48, 0, 1};

        jobs[0] = '{0, 0, 0, 10, 0};
        jobs[1] = '{1, 1, 1, 3, 1};
        jobs[2] = '{0, 2, 1, 1, 0};
        jobs[3] = '{0, 0, 0, 15, 0};   // done lands on the timeout cycle
        jobs[4] = '{15, 15, 0, 1, 0};

        arst = 1'b1;
        tick();
        tick();
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_start", tpu_start, 0);
        check("rst_cnt", tiles_done_cnt, 0);
        check("rst_err", sched_err, 0);
        check("rst_a", a_base_addr, 0);
        #2 arst = 1'b0;
        tick();
        check("idle_ready", cmd_ready, 1);

        // Command presented while busy is refused.
        send_cmd(0, 0, 0);
        wait_start(gap);
        tick();
        cmd_valid = 1'b1;
        cmd_m_m1  = 4'd5;
        tick();
        check("busy_ready", cmd_ready, 0);
        check("busy_flag", busy, 1);
        cmd_valid = 1'b0;
        pulse_done();
        check("busy_done", sched_done, 1);
        check("busy_cnt", tiles_done_cnt, 1);
        tick();

        for (int j = 0; j < 5; j++)
            run_job(jobs[j].m, jobs[j].n, jobs[j].k, jobs[j].delay, jobs[j].use_tbl);

        // Watchdog expiry, then a new command clears the error.
        run_timeout();
        run_job(0, 0, 0, 2, 0);

        // Abort in ERR clears the error flag.
        run_timeout();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_err_clr", sched_err, 0);
        check("abort_err_ready", cmd_ready, 1);

        // Abort in WAIT_DONE of tile 3 alongside tpu_done.
        send_cmd(1, 1, 1);
        for (int t = 0; t < 2; t++) begin
            wait_start(gap);
            repeat (2) tick();
            pulse_done();
        end
        wait_start(gap);
        check("ab_tile_n", tile_n, 1);
        repeat (3) tick();
        abort    = 1'b1;
        tpu_done = 1'b1;
        tick();
        abort    = 1'b0;
        tpu_done = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_ready", cmd_ready, 1);
        check("ab_done", sched_done, 0);
        check("ab_cnt", tiles_done_cnt, 2);
        check("ab_keep_n", tile_n, 1);
        tick();
        check("ab_done2", sched_done, 0);
        check("ab_start", tpu_start, 0);
        pulse_done();
        check("ab_ignored_done", tiles_done_cnt, 2);

        // Reset during ISSUE drops tpu_start without a clock edge.
        send_cmd(0, 1, 0);
        wait_start(gap);
        check("rs_start_hi", tpu_start, 1);
        #2 arst = 1'b1;
        #1;
        check("rs_start_lo", tpu_start, 0);
        check("rs_ready", cmd_ready, 1);
        check("rs_busy", busy, 0);
        check("rs_cnt", tiles_done_cnt, 0);
        check("rs_tile_n", tile_n, 0);
        #3 arst = 1'b0;
        tick();
        run_job(0, 1, 0, 4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
